// File: rtl/ascii_console.sv
// Character console front end: turns a stream of ASCII codes into text-buffer cell writes with cursor control.
// Optional build macro CONSOLE_TAB_EN: 0x09 advances the cursor to the next tab stop (every 8 columns).
module ascii_console #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  input  logic [23:0] char_color,
  output logic        char_ready,
  output logic        ascii_write_en,
  output logic [12:0] ascii_write_address,
  output logic [31:0] ascii_input,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy
);

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 6;
  localparam logic [7:0]  SPACE  = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_CLEAR_LINE,
    S_CLEAR_SCREEN
  } state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [23:0]         color_q, color_d;
  logic [7:0]          char_q, char_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                wrap_q, wrap_d;
  logic                do_lf;

  logic [ROW_W-1:0]    row_adv;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   adv_base;

  // Row advance wraps to the top; no scrolling.
  assign row_adv  = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
  assign cur_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
  assign adv_base = ADDR_W'(row_adv) * ADDR_W'(COLS);

`ifdef CONSOLE_TAB_EN
  localparam logic [7:0] COLS_B = 8'(COLS);
  logic [7:0] tab_col;
  assign tab_col = {1'b0, col_q[COL_W-1:3], 3'b000} + 8'd8;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR_SCREEN;
      col_q   <= '0;
      row_q   <= '0;
      color_q <= 24'hFFFFFF;
      char_q  <= SPACE;
      addr_q  <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      color_q <= color_d;
      char_q  <= char_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    color_d = color_q;
    char_d  = char_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    do_lf   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (char_valid && char_ready) begin
          color_d = char_color;
          char_d  = char_data;
          case (char_data)
            8'h0A: do_lf = 1'b1;
            8'h0D: col_d = '0;
            8'h08: begin
              if (col_q != '0) begin
                col_d   = col_q - COL_W'(1);
                addr_d  = cur_addr - ADDR_W'(1);
                char_d  = SPACE;
                wrap_d  = 1'b0;
                state_d = S_WRITE;
              end
            end
            8'h0C: begin
              col_d   = '0;
              row_d   = '0;
              addr_d  = '0;
              char_d  = SPACE;
              state_d = S_CLEAR_SCREEN;
            end
`ifdef CONSOLE_TAB_EN
            8'h09: begin
              if (tab_col >= COLS_B) do_lf = 1'b1;
              else                   col_d = tab_col[COL_W-1:0];
            end
`endif
            default: begin
              addr_d  = cur_addr;
              state_d = S_WRITE;
              if (col_q == COL_W'(COLS - 1)) begin
                col_d  = '0;
                row_d  = row_adv;
                wrap_d = 1'b1;
              end else begin
                col_d  = col_q + COL_W'(1);
                wrap_d = 1'b0;
              end
            end
          endcase
          // Line feed (or a tab past the last stop) clears the freshly entered row.
          if (do_lf) begin
            col_d   = '0;
            row_d   = row_adv;
            addr_d  = adv_base;
            cnt_d   = '0;
            char_d  = SPACE;
            state_d = S_CLEAR_LINE;
          end
        end
      end
      S_WRITE: begin
        wrap_d = 1'b0;
        if (wrap_q) begin
          addr_d  = cur_addr;
          cnt_d   = '0;
          char_d  = SPACE;
          state_d = S_CLEAR_LINE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR_LINE: begin
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(COLS - 1)) state_d = S_IDLE;
      end
      S_CLEAR_SCREEN: begin
        addr_d = addr_q + ADDR_W'(1);
        if (addr_q == ADDR_W'(ROWS * COLS - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held.
  assign char_ready          = !rst && (state_q == S_IDLE);
  assign busy                = rst || (state_q != S_IDLE);
  assign ascii_write_en      = !rst && (state_q != S_IDLE);
  assign ascii_write_address = rst ? '0 : addr_q;
  assign ascii_input         = rst ? '0 : {char_q, color_q};
  assign cursor_col          = col_q;
  assign cursor_row          = row_q;

endmodule

// File: tb/tb_ascii_console.sv
// Directed bench for ascii_console: reset clear, printable writes, wrap, LF/CR/BS/FF, tab and mid-clear reset.
module tb_ascii_console;

  logic        clk;
  logic        rst;
  logic        char_valid;
  logic [7:0]  char_data;
  logic [23:0] char_color;
  logic        char_ready;
  logic        ascii_write_en;
  logic [12:0] ascii_write_address;
  logic [31:0] ascii_input;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  int vectors;
  int miscompares;
  int wa[$];
  logic [31:0] wd[$];
  int low_cycles;

  ascii_console #(.COLS(80), .ROWS(60)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .char_valid          (char_valid),
    .char_data           (char_data),
    .char_color          (char_color),
    .char_ready          (char_ready),
    .ascii_write_en      (ascii_write_en),
    .ascii_write_address (ascii_write_address),
    .ascii_input         (ascii_input),
    .cursor_col          (cursor_col),
    .cursor_row          (cursor_row),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Collect writes until the block is ready again; low_cycles counts not-ready samples.
  task automatic run_idle(input int max_cyc);
    bit done;
    done = 1'b0;
    wa.delete();
    wd.delete();
    low_cycles = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (ascii_write_en) begin
        wa.push_back(int'(ascii_write_address));
        wd.push_back(ascii_input);
      end
      if (char_ready) done = 1'b1;
      else low_cycles++;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [7:0] c, input logic [23:0] color, input bit wait_idle);
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = c;
    char_color = color;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    if (wait_idle) run_idle(6000);
  endtask

  // Clear the screen, then walk the cursor to (col,row) with LFs and filler characters.
  task automatic place(input int col, input int row);
    send(8'h0C, 24'hFFFFFF, 1'b1);
    for (int r = 0; r < row; r++) send(8'h0A, 24'hFFFFFF, 1'b1);
    for (int c = 0; c < col; c++) send(8'h78, 24'h777777, 1'b1);
  endtask

  function automatic int range_bad(input int idx0, input int n, input int base, input logic [31:0] d);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      if (idx0 + k >= wa.size()) bad++;
      else if (wa[idx0 + k] != base + k || wd[idx0 + k] !== d) bad++;
    end
    return bad;
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    char_valid  = 1'b0;
    char_data   = 8'h00;
    char_color  = 24'h000000;

    // Reset held
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(char_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_we", 32'(ascii_write_en), 32'd0);
    check("rst_addr", 32'(ascii_write_address), 32'd0);
    check("rst_data", ascii_input, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Power-on clear
    run_idle(6000);
    check("clr_count", 32'(wa.size()), 32'd4800);
    check("clr_bad", 32'(range_bad(0, 4800, 0, 32'h20FFFFFF)), 32'd0);
    check("clr_ready", 32'(char_ready), 32'd1);
    check("clr_col", 32'(cursor_col), 32'd0);
    check("clr_row", 32'(cursor_row), 32'd0);

    // 'A' at (0,0)
    send(8'h41, 24'hFF0000, 1'b1);
    check("a_count", 32'(wa.size()), 32'd1);
    check("a_addr", 32'(wa[0]), 32'd0);
    check("a_data", wd[0], 32'h41FF0000);
    check("a_low", 32'(low_cycles), 32'd1);
    check("a_col", 32'(cursor_col), 32'd1);
    check("a_row", 32'(cursor_row), 32'd0);

    // 'Z' at end of row 5 wraps and clears row 6
    place(79, 5);
    check("z_pre_col", 32'(cursor_col), 32'd79);
    send(8'h5A, 24'h0000FF, 1'b1);
    check("z_count", 32'(wa.size()), 32'd81);
    check("z_addr", 32'(wa[0]), 32'd479);
    check("z_data", wd[0], 32'h5A0000FF);
    check("z_clr_bad", 32'(range_bad(1, 80, 480, 32'h200000FF)), 32'd0);
    check("z_col", 32'(cursor_col), 32'd0);
    check("z_row", 32'(cursor_row), 32'd6);

    // LF on the last row wraps to row 0
    place(3, 59);
    send(8'h0A, 24'h123456, 1'b1);
    check("lf_count", 32'(wa.size()), 32'd80);
    check("lf_bad", 32'(range_bad(0, 80, 0, 32'h20123456)), 32'd0);
    check("lf_col", 32'(cursor_col), 32'd0);
    check("lf_row", 32'(cursor_row), 32'd0);

    // CR stays idle
    place(3, 2);
    send(8'h0D, 24'h00FF00, 1'b1);
    check("cr_count", 32'(wa.size()), 32'd0);
    check("cr_low", 32'(low_cycles), 32'd0);
    check("cr_col", 32'(cursor_col), 32'd0);
    check("cr_row", 32'(cursor_row), 32'd2);

    // BS at column 0 is a no-op, at column 5 erases column 4
    place(0, 4);
    send(8'h08, 24'h00FF00, 1'b1);
    check("bs0_count", 32'(wa.size()), 32'd0);
    check("bs0_col", 32'(cursor_col), 32'd0);
    check("bs0_row", 32'(cursor_row), 32'd4);
    for (int c = 0; c < 5; c++) send(8'h78, 24'h777777, 1'b1);
    send(8'h08, 24'hABCDEF, 1'b1);
    check("bs_count", 32'(wa.size()), 32'd1);
    check("bs_addr", 32'(wa[0]), 32'd324);
    check("bs_data", wd[0], 32'h20ABCDEF);
    check("bs_col", 32'(cursor_col), 32'd4);
    check("bs_row", 32'(cursor_row), 32'd4);

    // Form feed clears with the captured colour
    send(8'h0C, 24'h010203, 1'b1);
    check("ff_count", 32'(wa.size()), 32'd4800);
    check("ff_bad", 32'(range_bad(0, 4800, 0, 32'h20010203)), 32'd0);
    check("ff_col", 32'(cursor_col), 32'd0);
    check("ff_row", 32'(cursor_row), 32'd0);

    // Tab at (3,1)
    send(8'h0A, 24'hFFFFFF, 1'b1);
    for (int c = 0; c < 3; c++) send(8'h78, 24'h777777, 1'b1);
    send(8'h09, 24'h0A0B0C, 1'b1);
`ifdef CONSOLE_TAB_EN
    check("tab_count", 32'(wa.size()), 32'd0);
    check("tab_col", 32'(cursor_col), 32'd8);
`else
    check("tab_count", 32'(wa.size()), 32'd1);
    check("tab_addr", 32'(wa[0]), 32'd83);
    check("tab_data", wd[0], 32'h090A0B0C);
    check("tab_col", 32'(cursor_col), 32'd4);
`endif
    check("tab_row", 32'(cursor_row), 32'd1);

    // Reset in the middle of a line clear restarts the screen clear at 0
    send(8'h0A, 24'h445566, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_we", 32'(ascii_write_en), 32'd0);
    check("mid_ready", 32'(char_ready), 32'd0);
    check("mid_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_idle(6000);
    check("mid_first", (wa.size() > 0) ? 32'(wa[0]) : 32'hFFFFFFFF, 32'd0);
    check("mid_count", 32'(wa.size()), 32'd4800);
    check("mid_bad", 32'(range_bad(0, 4800, 0, 32'h20FFFFFF)), 32'd0);
    check("mid_col", 32'(cursor_col), 32'd0);
    check("mid_row", 32'(cursor_row), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
